// File: rtl/mru_tracker.sv
// rtl/mru_tracker.sv - most-recently-used button recency stack with eviction pulse
module mru_tracker #(
    parameter  int N_BTN = 4,
    parameter  int DEPTH = 3,
    localparam int ID_W  = $clog2(N_BTN + 1),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             timedClk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] led,
    output logic [ID_W-1:0]  top_id,
    output logic [CNT_W-1:0] count,
    output logic             evict
);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPDATE,
        HOLD
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_stack [DEPTH];
    logic [ID_W-1:0]   r_pend;
    logic              r_evict;

    logic              w_btn_any;
    logic [ID_W-1:0]   w_low_id;
    logic              w_hit;
    logic [CNT_W-1:0]  w_hit_pos;
    logic              w_full;
    logic [ID_W-1:0]   w_next_stack [DEPTH];

    // Pick the lowest-numbered pressed button; higher ones are ignored.
    always_comb begin
        w_btn_any = |btn;
        w_low_id  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (btn[i]) begin
                w_low_id = ID_W'(i + 1);
            end
        end
    end

    // Locate the pending ID in the stack; empty entries hold 0 and never match a real ID.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_pos = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (!w_hit && (r_stack[j] == r_pend)) begin
                w_hit     = 1'b1;
                w_hit_pos = CNT_W'(j);
            end
        end
        w_full = (r_stack[DEPTH-1] != '0);
    end

    // Build the post-update stack: shift entries above the hit (or all on a miss), new ID on top.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_next_stack[i] = r_stack[i];
        end
        w_next_stack[0] = r_pend;
        for (int i = 1; i < DEPTH; i++) begin
            if (!w_hit || (i <= int'(w_hit_pos))) begin
                w_next_stack[i] = r_stack[i-1];
            end
        end
    end

    // Decode LEDs, top entry and occupancy straight from the stack registers.
    always_comb begin
        led   = '0;
        count = '0;
        for (int b = 0; b < N_BTN; b++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (r_stack[j] == ID_W'(b + 1)) begin
                    led[b] = 1'b1;
                end
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (r_stack[j] != '0) begin
                count = count + CNT_W'(1);
            end
        end
        top_id = r_stack[0];
        evict  = r_evict;
    end

    // Press-detect FSM: one update per press, then wait for full release.
    always_ff @(posedge timedClk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_pend  <= '0;
            r_evict <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_evict <= 1'b0;
            case (r_state)
                INIT: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stack[i] <= '0;
                    end
                    // A button still held from before reset must be released first.
                    r_state <= w_btn_any ? HOLD : IDLE;
                end
                IDLE: begin
                    if (w_btn_any) begin
                        r_pend  <= w_low_id;
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stack[i] <= w_next_stack[i];
                    end
                    r_evict <= !w_hit && w_full;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (!w_btn_any) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mru_tracker.sv
// tb/tb_mru_tracker.sv - scoreboard bench for mru_tracker
module tb_mru_tracker;

    localparam int N_BTN = 4;
    localparam int DEPTH = 3;

    logic       timedClk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] led;
    logic [2:0] top_id;
    logic [1:0] count;
    logic       evict;

    typedef struct packed {
        logic [2:0] top;
        logic [3:0] led;
        logic [1:0] cnt;
        logic       ev;
    } exp_t;

    exp_t sb [$];
    int   mstack [$];
    int   n_vec = 0;
    int   n_err = 0;

    mru_tracker #(.N_BTN(N_BTN), .DEPTH(DEPTH)) dut (
        .timedClk (timedClk),
        .rst      (rst),
        .btn      (btn),
        .led      (led),
        .top_id   (top_id),
        .count    (count),
        .evict    (evict)
    );

    always #5 timedClk = ~timedClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t snapshot(input logic ev);
        exp_t e;
        e.top = (mstack.size() > 0) ? 3'(mstack[0]) : 3'd0;
        e.led = 4'd0;
        foreach (mstack[k]) e.led[mstack[k]-1] = 1'b1;
        e.cnt = 2'(mstack.size());
        e.ev  = ev;
        return e;
    endfunction

    task automatic model_press(input logic [3:0] b, output logic ev);
        int id;
        int idx;
        id  = 0;
        idx = -1;
        ev  = 1'b0;
        for (int i = 3; i >= 0; i--) if (b[i]) id = i + 1;
        foreach (mstack[k]) if (mstack[k] == id) idx = k;
        if (idx >= 0) begin
            mstack.delete(idx);
        end else if (mstack.size() == DEPTH) begin
            void'(mstack.pop_back());
            ev = 1'b1;
        end
        mstack.push_front(id);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_top"},   32'(top_id), 32'(e.top));
            check({tag, "_led"},   32'(led),    32'(e.led));
            check({tag, "_count"}, 32'(count),  32'(e.cnt));
            check({tag, "_evict"}, 32'(evict),  32'(e.ev));
        end
    endtask

    // Press b, optionally keep a (possibly different) nonzero pattern held, then release.
    task automatic press(input string tag, input logic [3:0] b, input int hold, input logic [3:0] b_hold);
        logic ev;
        @(negedge timedClk);
        btn = b;
        sb.push_back(snapshot(1'b0));
        model_press(b, ev);
        sb.push_back(snapshot(ev));
        sb.push_back(snapshot(1'b0));
        @(posedge timedClk);
        #1 compare_out({tag, "_e0"});
        @(posedge timedClk);
        #1 compare_out({tag, "_e1"});
        @(posedge timedClk);
        #1 compare_out({tag, "_e2"});
        if (hold > 0) begin
            @(negedge timedClk);
            btn = b_hold;
            sb.push_back(snapshot(1'b0));
            repeat (hold) @(posedge timedClk);
            #1 compare_out({tag, "_hold"});
        end
        @(negedge timedClk);
        btn = 4'd0;
        sb.push_back(snapshot(1'b0));
        repeat (2) @(posedge timedClk);
        #1 compare_out({tag, "_rel"});
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_led"},   32'(led),    32'd0);
        check({tag, "_top"},   32'(top_id), 32'd0);
        check({tag, "_count"}, 32'(count),  32'd0);
        check({tag, "_evict"}, 32'(evict),  32'd0);
    endtask

    initial begin
        rst = 1'b1;
        btn = 4'd0;
        #1 check_empty("reset_async");
        repeat (2) @(posedge timedClk);
        @(negedge timedClk);
        rst = 1'b0;
        repeat (3) @(posedge timedClk);
        #1 check_empty("idle_after_reset");

        press("id2", 4'b0010, 0, 4'b0000);
        press("id4", 4'b1000, 0, 4'b0000);
        press("id1", 4'b0001, 0, 4'b0000);
        check("fill_led",   32'(led),    32'b1011);
        check("fill_top",   32'(top_id), 32'd1);
        check("fill_count", 32'(count),  32'd3);

        press("id3_evict", 4'b0100, 0, 4'b0000);
        check("evict_led", 32'(led),    32'b1101);
        check("evict_top", 32'(top_id), 32'd3);

        press("id4_hit",  4'b1000, 0, 4'b0000);
        check("hit_top",   32'(top_id), 32'd4);
        check("hit_count", 32'(count),  32'd3);
        press("id4_hit0", 4'b1000, 0, 4'b0000);

        press("multi_hold", 4'b0110, 7, 4'b0110);
        check("multi_top", 32'(top_id), 32'd2);
        press("hold_change", 4'b1000, 5, 4'b1001);
        check("change_top", 32'(top_id), 32'd4);

        // Reset while the press is pending in UPDATE, button kept down across release.
        @(negedge timedClk);
        btn = 4'b0001;
        @(posedge timedClk);
        #2 rst = 1'b1;
        #1 check_empty("reset_in_update");
        mstack.delete();
        sb.delete();
        repeat (2) @(posedge timedClk);
        @(negedge timedClk);
        rst = 1'b0;
        repeat (5) @(posedge timedClk);
        #1 check_empty("held_across_reset");
        @(negedge timedClk);
        btn = 4'd0;
        repeat (2) @(posedge timedClk);
        #1 check_empty("released_after_reset");
        press("id1_after_reset", 4'b0001, 0, 4'b0000);
        check("after_reset_count", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mru_tracker.md
MRU_TRACKER -- requirements
Module: mru_tracker

Interface
REQ-001 Parameter N_BTN, default 4, number of button channels; legal range 2..15.
REQ-002 Parameter DEPTH, default 3, number of recency-stack entries; legal range 1..N_BTN.
REQ-003 Derived constants: ID_W = clog2(N_BTN+1); CNT_W = clog2(DEPTH+1).
REQ-004 timedClk  input  1  clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 btn  input  N_BTN  button levels; btn[i] high means button ID i+1 is pressed.
REQ-007 led  output  N_BTN  led[i] high iff ID i+1 is in the stack.
REQ-008 top_id  output  ID_W  most-recently-used ID; 0 when the stack is empty.
REQ-009 count  output  CNT_W  number of valid stack entries, 0..DEPTH.
REQ-010 evict  output  1  one-cycle pulse when the oldest entry is dropped.

Function
REQ-011 Stack: DEPTH entries of ID_W bits each; entry 0 is the newest; value 0 means empty; valid entries are always contiguous from entry 0.
REQ-012 No ID appears more than once in the stack.
REQ-013 led, top_id and count are combinational decodes of the stack registers and add no latency.
REQ-014 FSM states: INIT, IDLE, UPDATE, HOLD.
REQ-015 INIT: clears the stack; on the next edge, goes to HOLD if btn != 0, otherwise to IDLE.
REQ-016 IDLE: on an edge with btn != 0, latches pend = index+1 of the lowest set bit of btn and goes to UPDATE; otherwise stays in IDLE.
REQ-017 UPDATE, hit case (pend in stack at position p): entries 0..p-1 shift down one, pend is written to entry 0, count is unchanged.
REQ-018 UPDATE, miss with count < DEPTH: all entries shift down one, pend is written to entry 0, count increments.
REQ-019 UPDATE, miss with count == DEPTH: entry DEPTH-1 is discarded, the remaining entries shift, pend is written to entry 0, and evict is high for exactly the cycle after this edge.
REQ-020 UPDATE always exits to HOLD on the next edge.
REQ-021 HOLD: stays while btn != 0; goes to IDLE on the first edge that samples btn == 0.
REQ-022 A held button registers as exactly one press; a new press is accepted only after all buttons are released.
REQ-023 Simultaneous presses: only the lowest index is recorded; the others are ignored until all buttons are released.
REQ-024 Latency: press sampled at edge E0 in IDLE; stack, led, top_id, count and evict change after edge E1.
REQ-025 Hit on entry 0: the stack is unchanged and evict stays low.
REQ-026 Changes on btn during UPDATE or HOLD do not alter pend.
REQ-027 When DEPTH == 1, every miss with count == 1 evicts.

Reset
REQ-028 While rst is high: state = INIT, all stack entries = 0, pend = 0, led = 0, top_id = 0, count = 0, evict = 0; this takes effect immediately, independent of timedClk.
REQ-029 Reset asserted in UPDATE or HOLD abandons the pending update; no partial stack write remains.
REQ-030 A button held across reset release does not register as a press.

Verification (N_BTN=4, DEPTH=3)
REQ-031 Reset, then btn=0 for 3 edges -> led=0000, top_id=0, count=0, evict=0.
REQ-032 Press then release IDs 2, 4, 1 in turn -> stack {1,4,2}, led=1011, top_id=1, count=3, no evict pulse.
REQ-033 From stack {1,4,2}, press ID 3 -> stack {3,1,4}, led=1101, evict high for exactly 1 cycle.
REQ-034 From stack {3,1,4}, press ID 4 -> stack {4,3,1}, count=3, evict=0; pressing ID 4 again leaves the stack unchanged.
REQ-035 btn=0110 held for 10 edges, then btn=0 -> exactly one update with ID 2; top_id=2.
REQ-036 Assert rst on the edge after a press is sampled; hold btn=0001 through reset release -> stack empty, count=0, no update until btn returns to 0 and is pressed again.
